exc_tracker: RTL and testbench

Exception-origination side of the precise-exception path: detects per-stage exception causes (fetch, decode, execute, memory), carries one exception record per pipeline register alongside the instruction, and presents the oldest committing instruction's exception to CP0 at the MEM/WB boundary. CP0 consumes `exception`/`exccode`/`badvaddr`/`epc_pc`/`is_delay_slot` and answers with its flush, which clears every record here.

---
 rtl/exc_tracker.sv | 168 ++++++++++++++++
 tb/tb_exc_tracker.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_tracker.sv
// Exception origination and precise-exception tracking: one exception record
// rides each pipeline register; the MEM/WB record is presented to CP0 at commit.
module exc_tracker (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        fd_load,
  input  logic        de_load,
  input  logic        em_load,
  input  logic        mw_load,
  input  logic [31:0] if_pc,
  input  logic        id_valid,
  input  logic        id_is_branch,
  input  logic        id_ri,
  input  logic        id_syscall,
  input  logic        id_break,
  input  logic        id_eret,
  input  logic        ex_ov,
  input  logic [31:0] mem_addr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic        mw_valid,
  input  logic        int_pending,
  output logic        exception,
  output logic [4:0]  exccode,
  output logic [31:0] badvaddr,
  output logic [31:0] epc_pc,
  output logic        is_delay_slot,
  output logic        mem_kill
);

  typedef struct packed {
    logic        exc;
    logic [4:0]  code;
    logic [31:0] badvaddr;
    logic [31:0] pc;
    logic        ds;
  } rec_t;

  localparam logic [4:0] CODE_INT  = 5'd0;
  localparam logic [4:0] CODE_ADEL = 5'd4;
  localparam logic [4:0] CODE_ADES = 5'd5;
  localparam logic [4:0] CODE_SYS  = 5'd8;
  localparam logic [4:0] CODE_BP   = 5'd9;
  localparam logic [4:0] CODE_RI   = 5'd10;
  localparam logic [4:0] CODE_OV   = 5'd12;
  localparam logic [4:0] CODE_ERET = 5'd31;

  // p0 = IF/ID, p1 = ID/EX, p2 = EX/MEM, p3 = MEM/WB
  rec_t        rec_p0, rec_p1, rec_p2, rec_p3;
  rec_t        fd_nxt, de_nxt, em_nxt, mw_nxt;
  logic        ds_flag;
  logic [31:0] last_badvaddr;
  logic        mem_misal;
  logic        commit_raise;
  logic        commit_addr_exc;

  function automatic logic misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
    logic m;
    case (size)
      2'd1:    m = addr_lo[0];
      2'd2:    m = (addr_lo != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  // An earlier-stage cause is never overwritten; ID causes follow RI > Sys > Bp > ERET.
  function automatic rec_t id_merge(input rec_t r, input logic ri, input logic sys,
                                    input logic brk, input logic eret);
    rec_t m;
    m = r;
    if (!r.exc) begin
      if (ri) begin
        m.exc  = 1'b1;
        m.code = CODE_RI;
      end else if (sys) begin
        m.exc  = 1'b1;
        m.code = CODE_SYS;
      end else if (brk) begin
        m.exc  = 1'b1;
        m.code = CODE_BP;
      end else if (eret) begin
        m.exc  = 1'b1;
        m.code = CODE_ERET;
      end
    end
    return m;
  endfunction

  assign mem_misal = (mem_rd | mem_wr) & misaligned(mem_addr[1:0], mem_size);

  always_comb begin
    fd_nxt    = '0;
    fd_nxt.pc = if_pc;
    if (if_pc[1:0] != 2'b00) begin
      fd_nxt.exc      = 1'b1;
      fd_nxt.code     = CODE_ADEL;
      fd_nxt.badvaddr = if_pc;
    end

    de_nxt    = id_merge(rec_p0, id_ri, id_syscall, id_break, id_eret);
    de_nxt.ds = ds_flag;

    em_nxt = rec_p1;
    if (!rec_p1.exc && ex_ov) begin
      em_nxt.exc  = 1'b1;
      em_nxt.code = CODE_OV;
    end

    mw_nxt = rec_p2;
    if (!rec_p2.exc && mem_misal) begin
      mw_nxt.exc      = 1'b1;
      mw_nxt.code     = mem_rd ? CODE_ADEL : CODE_ADES;
      mw_nxt.badvaddr = mem_addr;
    end
  end

  // Pipeline register captures: IF/ID, ID/EX, EX/MEM, MEM/WB
  always_ff @(posedge clk) begin
    if (reset) begin
      rec_p0        <= '0;
      rec_p1        <= '0;
      rec_p2        <= '0;
      rec_p3        <= '0;
      ds_flag       <= 1'b0;
      last_badvaddr <= '0;
    end else begin
      if (commit_raise && commit_addr_exc)
        last_badvaddr <= rec_p3.badvaddr;
      if (flush) begin
        rec_p0  <= '0;
        rec_p1  <= '0;
        rec_p2  <= '0;
        rec_p3  <= '0;
        ds_flag <= 1'b0;
      end else begin
        if (fd_load)
          rec_p0 <= fd_nxt;
        if (de_load) begin
          rec_p1 <= de_nxt;
          // Bubbles leave the flag alone so a slot behind a bubble is still marked.
          if (id_valid)
            ds_flag <= id_is_branch;
        end
        if (em_load)
          rec_p2 <= em_nxt;
        if (mw_load)
          rec_p3 <= mw_nxt;
      end
    end
  end

  // Commit stage: combinational presentation of the MEM/WB record
  assign commit_raise    = mw_valid & (rec_p3.exc | int_pending);
  assign commit_addr_exc = rec_p3.exc & ~int_pending &
                           ((rec_p3.code == CODE_ADEL) || (rec_p3.code == CODE_ADES));

  assign exception     = commit_raise;
  assign exccode       = int_pending ? CODE_INT : rec_p3.code;
  // Non-address causes replay the previous BadVAddr so CP0's write is a no-op.
  assign badvaddr      = commit_addr_exc ? rec_p3.badvaddr : last_badvaddr;
  assign epc_pc        = rec_p3.pc;
  assign is_delay_slot = rec_p3.ds;
  assign mem_kill      = rec_p2.exc | mem_misal | commit_raise;

endmodule

// File: tb/tb_exc_tracker.sv
// Directed bench for exc_tracker: a cause-list model of each in-flight
// instruction is compared every cycle, plus hand-computed literal checks.
module tb_exc_tracker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush, fd_load, de_load, em_load, mw_load;
  logic [31:0] if_pc;
  logic        id_valid, id_is_branch, id_ri, id_syscall, id_break, id_eret;
  logic        ex_ov;
  logic [31:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [1:0]  mem_size;
  logic        mw_valid = 1'b0;
  logic        int_pending = 1'b0;
  logic        exception;
  logic [4:0]  exccode;
  logic [31:0] badvaddr, epc_pc;
  logic        is_delay_slot, mem_kill;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  exc_tracker dut (
    .clk(clk), .reset(reset), .flush(flush),
    .fd_load(fd_load), .de_load(de_load), .em_load(em_load), .mw_load(mw_load),
    .if_pc(if_pc), .id_valid(id_valid), .id_is_branch(id_is_branch),
    .id_ri(id_ri), .id_syscall(id_syscall), .id_break(id_break), .id_eret(id_eret),
    .ex_ov(ex_ov), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_size(mem_size), .mw_valid(mw_valid), .int_pending(int_pending),
    .exception(exception), .exccode(exccode), .badvaddr(badvaddr),
    .epc_pc(epc_pc), .is_delay_slot(is_delay_slot), .mem_kill(mem_kill)
  );

  // Model: each in-flight instruction keeps every cause it ever saw; the
  // earliest-detected one is chosen only when it is presented.
  typedef struct {
    bit        fetch;
    bit [31:0] faddr;
    bit        idx;
    bit [4:0]  idc;
    bit        ov;
    bit        memx;
    bit [4:0]  memc;
    bit [31:0] maddr;
    bit [31:0] pc;
    bit        ds;
  } minst_t;

  minst_t    m_zero;
  minst_t    m_fd, m_de, m_em, m_mw;
  bit        m_dsflag;
  bit [31:0] m_last;

  function automatic bit first_cause(input minst_t r, output bit [4:0] code, output bit [31:0] addr);
    code = 5'd0;
    addr = 32'd0;
    if (r.fetch) begin code = 5'd4; addr = r.faddr; return 1'b1; end
    if (r.idx)   begin code = r.idc; return 1'b1; end
    if (r.ov)    begin code = 5'd12; return 1'b1; end
    if (r.memx)  begin code = r.memc; addr = r.maddr; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic bit m_misal(input bit [31:0] a, input bit [1:0] s);
    return (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0);
  endfunction

  function automatic void model_out(output bit ex, output bit [4:0] cc, output bit [31:0] bv,
                                    output bit [31:0] pc, output bit ds, output bit mk);
    bit        has, em_has;
    bit [4:0]  c, c2;
    bit [31:0] a, a2;
    has    = first_cause(m_mw, c, a);
    em_has = first_cause(m_em, c2, a2);
    ex = mw_valid && (has || int_pending);
    cc = int_pending ? 5'd0 : c;
    bv = (!int_pending && has && (c == 5'd4 || c == 5'd5)) ? a : m_last;
    pc = m_mw.pc;
    ds = m_mw.ds;
    mk = ex || em_has || ((mem_rd || mem_wr) && m_misal(mem_addr, mem_size));
  endfunction

  always @(posedge clk) begin
    bit        ex, ds, mk;
    bit [4:0]  cc;
    bit [31:0] bv, pc;
    minst_t    nfd, nde, nem, nmw;
    model_out(ex, cc, bv, pc, ds, mk);
    if (reset) begin
      m_fd = m_zero; m_de = m_zero; m_em = m_zero; m_mw = m_zero;
      m_dsflag = 1'b0;
      m_last = 32'd0;
    end else begin
      if (ex && !int_pending && (cc == 5'd4 || cc == 5'd5))
        m_last = bv;
      if (flush) begin
        m_fd = m_zero; m_de = m_zero; m_em = m_zero; m_mw = m_zero;
        m_dsflag = 1'b0;
      end else begin
        nfd = m_fd; nde = m_de; nem = m_em; nmw = m_mw;
        if (mw_load) begin
          nmw = m_em;
          if ((mem_rd || mem_wr) && m_misal(mem_addr, mem_size)) begin
            nmw.memx  = 1'b1;
            nmw.memc  = mem_rd ? 5'd4 : 5'd5;
            nmw.maddr = mem_addr;
          end
        end
        if (em_load) begin
          nem = m_de;
          nem.ov = ex_ov;
        end
        if (de_load) begin
          nde = m_fd;
          nde.ds = m_dsflag;
          nde.idx = id_ri || id_syscall || id_break || id_eret;
          if (id_eret)    nde.idc = 5'd31;
          if (id_break)   nde.idc = 5'd9;
          if (id_syscall) nde.idc = 5'd8;
          if (id_ri)      nde.idc = 5'd10;
          if (id_valid) m_dsflag = id_is_branch;
        end
        if (fd_load) begin
          nfd = m_zero;
          nfd.pc    = if_pc;
          nfd.faddr = if_pc;
          nfd.fetch = (if_pc % 4 != 0);
        end
        m_fd = nfd; m_de = nde; m_em = nem; m_mw = nmw;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit        ex, ds, mk;
    bit [4:0]  cc;
    bit [31:0] bv, pc;
    if (started) begin
      model_out(ex, cc, bv, pc, ds, mk);
      chk("exception", 32'(exception), 32'(ex));
      chk("exccode", 32'(exccode), 32'(cc));
      chk("badvaddr", badvaddr, bv);
      chk("epc_pc", epc_pc, pc);
      chk("is_delay_slot", 32'(is_delay_slot), 32'(ds));
      chk("mem_kill", 32'(mem_kill), 32'(mk));
    end
  end

  task automatic clr();
    flush = 0; fd_load = 0; de_load = 0; em_load = 0; mw_load = 0;
    if_pc = 0; id_valid = 0; id_is_branch = 0; id_ri = 0; id_syscall = 0;
    id_break = 0; id_eret = 0; ex_ov = 0; mem_addr = 0; mem_rd = 0; mem_wr = 0; mem_size = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic ri, input logic sys,
                      input logic br, input logic ov);
    if_pc = pc; fd_load = 1; step();
    de_load = 1; id_valid = 1; id_ri = ri; id_syscall = sys; id_is_branch = br; step();
    em_load = 1; ex_ov = ov; step();
    mw_load = 1; step();
  endtask

  initial begin
    clr();
    step();
    started = 1'b1;
    step();
    chk("rst_exception", 32'(exception), 32'd0);
    chk("rst_exccode", 32'(exccode), 32'd0);
    chk("rst_badvaddr", badvaddr, 32'd0);
    chk("rst_epc", epc_pc, 32'd0);
    chk("rst_ds", 32'(is_delay_slot), 32'd0);
    chk("rst_mem_kill", 32'(mem_kill), 32'd0);
    reset = 0;
    mw_valid = 1;

    // Fetch AdEL travels to commit and stays presented while stalled
    if_pc = 32'hBFC00002; fd_load = 1; step();
    de_load = 1; id_valid = 1; step();
    em_load = 1; step();
    chk("fetch_mem_kill", 32'(mem_kill), 32'd1);
    mw_load = 1; step();
    chk("fetch_exception", 32'(exception), 32'd1);
    chk("fetch_exccode", 32'(exccode), 32'd4);
    chk("fetch_badvaddr", badvaddr, 32'hBFC00002);
    chk("fetch_epc", epc_pc, 32'hBFC00002);
    step(); step();
    chk("stall_exception", 32'(exception), 32'd1);
    mw_valid = 0; #1;
    chk("novalid_exception", 32'(exception), 32'd0);
    mw_valid = 1;
    flush = 1; step();
    chk("flush_exception", 32'(exception), 32'd0);
    chk("flush_epc", epc_pc, 32'd0);

    // Branch then syscall in its delay slot
    if_pc = 32'h100; fd_load = 1; step();
    de_load = 1; id_valid = 1; id_is_branch = 1; if_pc = 32'h104; fd_load = 1; step();
    de_load = 1; id_valid = 1; id_syscall = 1; step();
    em_load = 1; step();
    mw_load = 1; step();
    chk("slot_exccode", 32'(exccode), 32'd8);
    chk("slot_ds", 32'(is_delay_slot), 32'd1);
    chk("slot_epc", epc_pc, 32'h104);
    flush = 1; step();

    // Same with an invalid bubble between branch and slot
    if_pc = 32'h100; fd_load = 1; step();
    de_load = 1; id_valid = 1; id_is_branch = 1; step();
    de_load = 1; step();
    if_pc = 32'h104; fd_load = 1; step();
    de_load = 1; id_valid = 1; id_syscall = 1; step();
    em_load = 1; step();
    mw_load = 1; step();
    chk("bubble_exccode", 32'(exccode), 32'd8);
    chk("bubble_ds", 32'(is_delay_slot), 32'd1);
    chk("bubble_epc", epc_pc, 32'h104);
    flush = 1; step();
    push(32'h108, 0, 0, 0, 0);
    chk("after_flush_ds", 32'(is_delay_slot), 32'd0);
    flush = 1; step();

    // Misaligned store word, then a Sys commit keeps the old BadVAddr
    if_pc = 32'h200; fd_load = 1; step();
    de_load = 1; id_valid = 1; step();
    em_load = 1; step();
    mem_wr = 1; mem_size = 2; mem_addr = 32'h80000006; #1;
    chk("ades_mem_kill", 32'(mem_kill), 32'd1);
    mw_load = 1; step();
    chk("ades_exception", 32'(exception), 32'd1);
    chk("ades_exccode", 32'(exccode), 32'd5);
    chk("ades_badvaddr", badvaddr, 32'h80000006);
    flush = 1; step();
    push(32'h300, 0, 1, 0, 0);
    chk("sys_exccode", 32'(exccode), 32'd8);
    chk("sys_badvaddr", badvaddr, 32'h80000006);
    flush = 1; step();
    mem_wr = 1; mem_size = 0; mem_addr = 32'h80000007; #1;
    chk("byte_no_kill", 32'(mem_kill), 32'd0);
    mem_wr = 0; mem_rd = 1; mem_size = 1; mem_addr = 32'h2; #1;
    chk("half_aligned_no_kill", 32'(mem_kill), 32'd0);
    mem_addr = 32'h3; #1;
    chk("half_odd_kill", 32'(mem_kill), 32'd1);
    clr(); #1;

    // Earliest cause wins
    push(32'h400, 1, 0, 0, 1);
    chk("ri_over_ov", 32'(exccode), 32'd10);
    flush = 1; step();
    push(32'h402, 1, 0, 0, 0);
    chk("adel_over_ri", 32'(exccode), 32'd4);
    chk("adel_over_ri_bva", badvaddr, 32'h402);
    flush = 1; step();

    // Interrupt at commit, then flush racing a de_load
    push(32'h500, 0, 0, 0, 0);
    int_pending = 1; #1;
    chk("int_exception", 32'(exception), 32'd1);
    chk("int_exccode", 32'(exccode), 32'd0);
    chk("int_epc", epc_pc, 32'h500);
    chk("int_badvaddr", badvaddr, 32'h402);
    mw_valid = 0; #1;
    chk("int_novalid", 32'(exception), 32'd0);
    mw_valid = 1;
    if_pc = 32'h600; fd_load = 1; step();
    flush = 1; de_load = 1; id_valid = 1; id_ri = 1; step();
    int_pending = 0; #1;
    chk("flushde_exception", 32'(exception), 32'd0);
    chk("flushde_epc", epc_pc, 32'd0);
    em_load = 1; step();
    mw_load = 1; step();
    chk("flushde_drain_exc", 32'(exception), 32'd0);
    chk("flushde_drain_epc", epc_pc, 32'd0);

    // Reset with every stage holding an excepting record
    if_pc = 32'h11; fd_load = 1; step();
    for (int i = 0; i < 3; i++) begin
      if_pc = 32'h21; fd_load = 1; de_load = 1; em_load = 1; mw_load = 1;
      id_valid = 1; id_is_branch = 1; id_ri = 1; step();
    end
    chk("prereset_exception", 32'(exception), 32'd1);
    step();
    reset = 1; step();
    reset = 0; #1;
    chk("reset_exception", 32'(exception), 32'd0);
    chk("reset_badvaddr", badvaddr, 32'd0);
    chk("reset_epc", epc_pc, 32'd0);
    push(32'h700, 0, 0, 0, 0);
    chk("reset_ds_clear", 32'(is_delay_slot), 32'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
